// File: rtl/sub_counter_bank.sv
// rtl/sub_counter_bank.sv - bank of saturating/wrapping counters with accumulators under a start/run/done FSM
// Each channel counts to LIMIT while enabled in RUN; the run ends one cycle after every channel has hit.
module sub_counter_bank #(
   parameter int               WIDTH     = 32,
   parameter int               ACC_WIDTH = 311,
   parameter int               CHANNELS  = 4,
   parameter logic [WIDTH-1:0] LIMIT     = 3,
   parameter int               WRAP_MODE = 0,
   parameter int               FINISH_EN = 0
) (
   input  logic                          clk,
   input  logic                          reset_l,
   input  logic                          start,
   input  logic [CHANNELS-1:0]           en,
   output logic [CHANNELS*WIDTH-1:0]     count,
   output logic [CHANNELS*ACC_WIDTH-1:0] acc,
   output logic [CHANNELS-1:0]           hit,
   output logic                          busy,
   output logic                          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   start_run;
   logic   run;

   logic [WIDTH-1:0]     cnt_q [CHANNELS];
   logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
   logic                 hit_q [CHANNELS];

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DONE is decided from the registered hit vector, giving one cycle of latency.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (&hit) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RUN);
      done      = (state_q == S_DONE);
      run       = (state_q == S_RUN);
      start_run = start && (state_q != S_RUN);
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      always_ff @(posedge clk) begin
         if (!reset_l) begin
            cnt_q[g] <= '0;
            acc_q[g] <= '0;
            hit_q[g] <= 1'b0;
         end else if (start_run) begin
            cnt_q[g] <= '0;
            acc_q[g] <= '0;
            hit_q[g] <= 1'b0;
         end else if (run && en[g]) begin
            acc_q[g] <= acc_q[g] + ACC_WIDTH'(cnt_q[g]);
            if (cnt_q[g] < LIMIT) begin
               cnt_q[g] <= cnt_q[g] + WIDTH'(1);
               if ((cnt_q[g] + WIDTH'(1)) == LIMIT) begin
                  hit_q[g] <= 1'b1;
               end
            end else begin
               // Sitting at LIMIT also covers LIMIT==0, where the first enabled cycle hits.
               hit_q[g] <= 1'b1;
               if (WRAP_MODE != 0) begin
                  cnt_q[g] <= '0;
               end
            end
         end
      end

      assign count[g*WIDTH +: WIDTH]       = cnt_q[g];
      assign acc[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g];
      assign hit[g]                        = hit_q[g];

      always_ff @(posedge clk) begin
         assert (!reset_l || cnt_q[g] <= LIMIT);
      end

      cover property (@(posedge clk) reset_l && $rose(hit_q[g]));

      if (WRAP_MODE != 0) begin : g_wrap_cov
         cover property (@(posedge clk) reset_l && run && en[g] && (cnt_q[g] == LIMIT));
      end
   end

   always_ff @(posedge clk) begin
      assert (!(busy && done));
   end

   cover property (@(posedge clk) reset_l && state_q == S_RUN && state_d == S_DONE);

   if (FINISH_EN != 0) begin : g_finish
      always_ff @(posedge clk) begin
         if (reset_l && state_q == S_RUN && state_d == S_DONE) begin
            $write("*-* All Finished *-*\n");
            $finish;
         end
      end
   end

endmodule
